// File: rtl/vid_sync_gen_if.sv
// Raster timing bundle from the sync generator to the pixel pipe.
// The master drives it; every downstream stage attaches through the slave view.
interface vid_sync_gen_if;
    logic [3:0]  pc_ena;
    logic        hde;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic        line_start;
    logic        frame_start;

    modport master (
        output pc_ena, hde, vde, hs, vs, x, y, line_start, frame_start
    );

    modport slave (
        input  pc_ena, hde, vde, hs, vs, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vid_sync_gen.sv
// Free-running raster timing generator at the head of the pixel pipe.
// A pixel-phase counter gates the horizontal/vertical counters.  The syncs,
// enables and coordinates are registered decodes of those counters, so they
// trail the counters by one pixel step and stay mutually aligned.
// Syncs are active-high; any polarity inversion happens downstream.
module vid_sync_gen #(
    parameter int H_RES   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_RES   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int PIX_DIV = 0
) (
    input  logic           pclk,
    input  logic           reset,
    vid_sync_gen_if.master vo
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Region boundaries are 13 bits wide: a 4096-wide total puts the end of
    // sync at 4096, which a 12-bit constant cannot represent.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_RES);
    localparam logic [12:0] V_ACT    = 13'(V_RES);
    localparam logic [12:0] HS_BEG   = 13'(H_RES + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_RES + H_FP + H_SYNC);
    localparam logic [12:0] VS_BEG   = 13'(V_RES + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_RES + V_FP + V_SYNC);
    localparam logic [3:0]  PC_LAST  = 4'(PIX_DIV);

    logic [3:0]  pc_cnt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        pix_step;

    logic [11:0] x_q;
    logic [11:0] y_q;
    logic        hde_q;
    logic        vde_q;
    logic        hs_q;
    logic        vs_q;
    logic        line_start_q;
    logic        frame_start_q;

    logic [12:0] h_ext;
    logic [12:0] v_ext;

    assign pix_step = (pc_cnt == 4'd0);
    assign h_ext    = {1'b0, h_cnt};
    assign v_ext    = {1'b0, v_cnt};

    // Pixel phase: counts 0..PIX_DIV and wraps; phase 0 marks a pixel step.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order; blocking here would
    // make results depend on evaluation order between always blocks.
    // NOTE: every flop, including the decoded outputs, clears on the async
    // reset so nothing downstream sees a stale sync or enable after reset.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            pc_cnt <= 4'd0;
        end else if (pc_cnt == PC_LAST) begin
            pc_cnt <= 4'd0;
        end else begin
            pc_cnt <= pc_cnt + 4'd1;
        end
    end

    // Raster position: advance h_cnt each pixel step, v_cnt at end of line.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (pix_step) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 12'd0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Timing outputs: register the decode of the current position per step.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x_q           <= 12'd0;
            y_q           <= 12'd0;
            hde_q         <= 1'b0;
            vde_q         <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_step) begin
            x_q           <= h_cnt;
            y_q           <= v_cnt;
            hde_q         <= (h_ext < H_ACT);
            vde_q         <= (v_ext < V_ACT);
            hs_q          <= (h_ext >= HS_BEG) && (h_ext < HS_END);
            vs_q          <= (v_ext >= VS_BEG) && (v_ext < VS_END);
            line_start_q  <= (h_cnt == 12'd0);
            frame_start_q <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

    assign vo.pc_ena      = pc_cnt;
    assign vo.x           = x_q;
    assign vo.y           = y_q;
    assign vo.hde         = hde_q;
    assign vo.vde         = vde_q;
    assign vo.hs          = hs_q;
    assign vo.vs          = vs_q;
    assign vo.line_start  = line_start_q;
    assign vo.frame_start = frame_start_q;

endmodule

// File: tb/tb_vid_sync_gen.sv
// Directed bench for vid_sync_gen.
// Three instances share clock and reset: default 640x480 timing (line checks),
// a small raster with PIX_DIV=0 (full-frame, wrap and mid-frame reset checks)
// and the same small raster with PIX_DIV=3 (divider checks).
// Small raster: H 8+2+3+3 = 16 pixels, V 4+2+2+2 = 10 lines.
module tb_vid_sync_gen;

    logic pclk;
    logic reset;

    int checks;
    int failures;

    vid_sync_gen_if d_if ();
    vid_sync_gen_if s_if ();
    vid_sync_gen_if p_if ();

    vid_sync_gen dut_d (
        .pclk  (pclk),
        .reset (reset),
        .vo    (d_if)
    );

    vid_sync_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIX_DIV(0)
    ) dut_s (
        .pclk  (pclk),
        .reset (reset),
        .vo    (s_if)
    );

    vid_sync_gen #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIX_DIV(3)
    ) dut_p (
        .pclk  (pclk),
        .reset (reset),
        .vo    (p_if)
    );

    // Flag order everywhere: {hde, vde, hs, vs, line_start, frame_start}
    logic [5:0]  d_fl, s_fl, p_fl;
    logic [33:0] d_all, s_all, p_all;

    assign d_fl  = {d_if.hde, d_if.vde, d_if.hs, d_if.vs, d_if.line_start, d_if.frame_start};
    assign s_fl  = {s_if.hde, s_if.vde, s_if.hs, s_if.vs, s_if.line_start, s_if.frame_start};
    assign p_fl  = {p_if.hde, p_if.vde, p_if.hs, p_if.vs, p_if.line_start, p_if.frame_start};
    assign d_all = {d_if.pc_ena, d_fl, d_if.x, d_if.y};
    assign s_all = {s_if.pc_ena, s_fl, s_if.x, s_if.y};
    assign p_all = {p_if.pc_ena, p_fl, p_if.x, p_if.y};

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 ns later.
    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Expected flags of the small raster at pixel (px, py).
    function automatic logic [5:0] small_flags(input int px, input int py);
        return {px < 8, py < 4, (px >= 10) && (px < 13), (py >= 6) && (py < 8),
                px == 0, (px == 0) && (py == 0)};
    endfunction

    initial begin
        int hde_n, hs_n, hs_first, hs_last, ls_n, err_d;
        int err_s, vs_n, fs_n, vs_bad, err_p, chg_bad, ls_p_n;
        logic        prev_vs;
        logic [3:0]  prev_pc;
        logic [33:0] prev_p;
        logic [19:0] pc_seq;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;

        // ---- reset held 5 clocks: all outputs zero
        tick(5);
        check("reset_d", 48'(d_all), 48'd0);
        check("reset_s", 48'(s_all), 48'd0);
        check("reset_p", 48'(p_all), 48'd0);

        #4 reset = 1'b0;

        // ---- default timing: first line, one sample per clock
        hde_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; err_d = 0;
        tick(1);
        check("start_flags", 48'(d_fl), 48'(6'b110011));
        check("start_xy", 48'({d_if.x, d_if.y}), 48'd0);
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick(1);
            if (d_if.x !== 12'(i) || d_if.y !== 12'd0) err_d++;
            if (d_if.hde !== (i < 640)) err_d++;
            if (d_if.hde) hde_n++;
            if (d_if.hs) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_if.line_start) ls_n++;
            if (i == 1) begin
                check("second_x", 48'(d_if.x), 48'd1);
                check("second_ls_fs", 48'({d_if.line_start, d_if.frame_start}), 48'd0);
            end
        end
        check("line_seq_err", 48'(err_d), 48'd0);
        check("hde_clocks", 48'(hde_n), 48'd640);
        check("hs_clocks", 48'(hs_n), 48'd96);
        check("hs_first_x", 48'(hs_first), 48'd656);
        check("hs_last_x", 48'(hs_last), 48'd751);
        check("ls_per_line", 48'(ls_n), 48'd1);
        tick(1);
        check("line_wrap_xy", 48'({d_if.x, d_if.y}), 48'({12'd0, 12'd1}));
        check("line_wrap_flags", 48'(d_fl), 48'(6'b110010));

        // ---- async reset pulse between edges, then restart
        #1 reset = 1'b1;
        #1;
        check("async_rst_d", 48'(d_all), 48'd0);
        tick(2);
        #4 reset = 1'b0;

        // ---- small raster, one full frame: PIX_DIV=0 and PIX_DIV=3 together
        err_s = 0; vs_n = 0; fs_n = 0; vs_bad = 0;
        err_p = 0; chg_bad = 0; ls_p_n = 0; pc_seq = 20'd0;
        prev_vs = 1'b0; prev_pc = 4'd0; prev_p = 34'd0;
        tick(1);
        for (int i = 0; i < 160; i++) begin
            int pidx;
            if (i > 0) tick(1);
            // PIX_DIV=0 instance
            if (s_if.x !== 12'(i % 16) || s_if.y !== 12'(i / 16)) err_s++;
            if (s_fl !== small_flags(i % 16, i / 16)) err_s++;
            if (s_if.vs) vs_n++;
            if (s_if.frame_start) fs_n++;
            if (i > 0 && s_if.vs !== prev_vs && s_if.x !== 12'd0) vs_bad++;
            prev_vs = s_if.vs;
            // PIX_DIV=3 instance
            pidx = i / 4;
            if (p_if.pc_ena !== 4'((i + 1) % 4)) err_p++;
            if (p_if.x !== 12'(pidx % 16) || p_if.y !== 12'(pidx / 16)) err_p++;
            if (p_fl !== small_flags(pidx % 16, pidx / 16)) err_p++;
            if (i > 0 && p_all[29:0] !== prev_p[29:0] && prev_pc !== 4'd0) chg_bad++;
            if (p_if.line_start) ls_p_n++;
            if (i < 5) pc_seq = {pc_seq[15:0], p_if.pc_ena};
            prev_pc = p_if.pc_ena;
            prev_p  = p_all;
        end
        check("frame_last_xy", 48'({s_if.x, s_if.y}), 48'({12'd15, 12'd9}));
        check("frame_last_vs", 48'(s_if.vs), 48'd0);
        check("frame_seq_err", 48'(err_s), 48'd0);
        check("vs_clocks", 48'(vs_n), 48'd32);
        check("fs_per_frame", 48'(fs_n), 48'd1);
        check("vs_only_at_x0", 48'(vs_bad), 48'd0);
        check("div_seq_err", 48'(err_p), 48'd0);
        check("div_change_off_step", 48'(chg_bad), 48'd0);
        check("div_pc_cycle", 48'(pc_seq), 48'(20'h12301));
        check("div_ls_clocks", 48'(ls_p_n), 48'd12);

        tick(1);
        check("frame_wrap_xy", 48'({s_if.x, s_if.y}), 48'd0);
        check("frame_wrap_flags", 48'(s_fl), 48'(6'b110011));

        // ---- mid-frame reset on the small raster at y=2
        tick(37);
        check("pre_rst_xy", 48'({s_if.x, s_if.y}), 48'({12'd5, 12'd2}));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_s", 48'(s_all), 48'd0);
        check("mid_rst_p", 48'(p_all), 48'd0);
        check("mid_rst_d", 48'(d_all), 48'd0);
        tick(3);
        #4 reset = 1'b0;
        tick(1);
        check("restart_s", 48'({s_fl, s_if.x, s_if.y}), 48'({6'b110011, 24'd0}));
        check("restart_p", 48'(p_all), 48'({4'd1, 6'b110011, 24'd0}));
        check("restart_d", 48'({d_fl, d_if.x, d_if.y}), 48'({6'b110011, 24'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
